// File: rtl/controlador_t_regs_pkg.sv
// controlador_t_regs_pkg: shared T codes, opcodes, ULA ops, state encoding and decode helpers
//   no ports; imported by the controller top
package controlador_t_regs_pkg;
   localparam logic [1:0] T_RST  = 2'b00;
   localparam logic [1:0] T_LOAD = 2'b01;
   localparam logic [1:0] T_HOLD = 2'b10;
   localparam logic [2:0] OP_CLRALL = 3'b000;
   localparam logic [2:0] OP_LOADX  = 3'b001;
   localparam logic [2:0] OP_LOADY  = 3'b010;
   localparam logic [2:0] OP_ADD    = 3'b011;
   localparam logic [2:0] OP_SUB    = 3'b100;
   localparam logic [2:0] OP_AND    = 3'b101;
   localparam logic [2:0] OP_OR     = 3'b110;
   localparam logic [2:0] OP_NOP    = 3'b111;
   localparam logic [1:0] ULA_ADD = 2'b00;
   localparam logic [1:0] ULA_SUB = 2'b01;
   localparam logic [1:0] ULA_AND = 2'b10;
   localparam logic [1:0] ULA_OR  = 2'b11;
   typedef enum logic [3:0] {
      ST_INIT, ST_IDLE, ST_DECODE, ST_CLEAR, ST_LDX, ST_LDY, ST_EXEC, ST_WRZ, ST_FIN
   } state_e;
   function automatic state_e dec_state(input logic [2:0] op);
      return op == OP_CLRALL ? ST_CLEAR :
             op == OP_LOADX  ? ST_LDX   :
             op == OP_LOADY  ? ST_LDY   :
             op == OP_NOP    ? ST_FIN   : ST_EXEC;
   endfunction
   // ALU opcodes 011..110 are consecutive, so the ULA code is the offset from ADD
   function automatic logic [1:0] ula_of(input logic [2:0] op);
      return 2'(op - OP_ADD);
   endfunction
endpackage

// File: rtl/controlador_t_regs_contador_exec.sv
// contador_exec: down-counter with load/enable and zero flag for the ULA settle time
//   clk, rst (async high) | load_i, val_i: load value | en_i: decrement | zero_o: count is 0
module contador_exec #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   input  logic             en_i,
   output logic             zero_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/controlador_t_regs.sv
// controlador_t_regs: FSM sequencing Tx/Ty/Tz T controls and ULA op per handshaked instruction
//   clk, rst (async high) | req, instr: instruction request | ack, done, busy: handshake status
//   tx, ty, tz: T controls (00 reset, 01 load, 10 hold) | ula_op: 00 add, 01 sub, 10 and, 11 or
module controlador_t_regs
   import controlador_t_regs_pkg::*;
#(
   parameter int EXEC_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [2:0] instr,
   output logic       ack,
   output logic       done,
   output logic       busy,
   output logic [1:0] tx,
   output logic [1:0] ty,
   output logic [1:0] tz,
   output logic [1:0] ula_op
);
   localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);
   state_e     state_q;
   logic [2:0] op_q;
   logic       ack_q, done_q, busy_q, cnt_zero;
   logic [1:0] tx_q, ty_q, tz_q, ula_q;
   // counter is loaded while leaving DECODE so it holds EXEC_CYCLES-1 on EXEC entry
   contador_exec #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .load_i(state_q == ST_DECODE),
      .val_i (EXEC_LOAD),
      .en_i  (state_q == ST_EXEC),
      .zero_o(cnt_zero)
   );
   // outputs are registered from the current state, so they trail it by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_INIT;
         op_q    <= OP_NOP;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         tx_q    <= T_RST;
         ty_q    <= T_RST;
         tz_q    <= T_RST;
         ula_q   <= ULA_ADD;
      end else begin
         ack_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b1;
         tx_q   <= T_HOLD;
         ty_q   <= T_HOLD;
         tz_q   <= T_HOLD;
         case (state_q)
            ST_INIT: begin
               tx_q    <= T_RST;
               ty_q    <= T_RST;
               tz_q    <= T_RST;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               ack_q  <= req;
               busy_q <= req;
               if (req) begin
                  op_q    <= instr;
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state_q <= dec_state(op_q);
               if (dec_state(op_q) == ST_EXEC) ula_q <= ula_of(op_q);
            end
            ST_CLEAR: begin
               tx_q    <= T_RST;
               ty_q    <= T_RST;
               tz_q    <= T_RST;
               state_q <= ST_FIN;
            end
            ST_LDX: begin
               tx_q    <= T_LOAD;
               state_q <= ST_FIN;
            end
            ST_LDY: begin
               ty_q    <= T_LOAD;
               state_q <= ST_FIN;
            end
            ST_EXEC: if (cnt_zero) state_q <= ST_WRZ;
            ST_WRZ: begin
               tz_q    <= T_LOAD;
               state_q <= ST_FIN;
            end
            ST_FIN: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               tx_q    <= T_RST;
               ty_q    <= T_RST;
               tz_q    <= T_RST;
               busy_q  <= 1'b0;
               state_q <= ST_INIT;
            end
         endcase
      end
   end
   assign ack    = ack_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign tx     = tx_q;
   assign ty     = ty_q;
   assign tz     = tz_q;
   assign ula_op = ula_q;
endmodule

// File: tb/tb_controlador_t_regs.sv
// tb_controlador_t_regs: directed self-checking bench for controlador_t_regs
module tb_controlador_t_regs;
   logic       clk = 1'b0, rst = 1'b1, req = 1'b0;
   logic [2:0] instr = 3'b111;
   logic       ack, done, busy;
   logic [1:0] tx, ty, tz, ula_op;
   int         n_chk = 0, n_fail = 0;
   // packed view {ack, done, busy, tx, ty, tz}
   localparam logic [8:0] ZERO = 9'b000_00_00_00;
   localparam logic [8:0] IDL  = 9'b000_10_10_10;
   localparam logic [8:0] ACK  = 9'b101_10_10_10;
   localparam logic [8:0] BSY  = 9'b001_10_10_10;
   localparam logic [8:0] DON  = 9'b011_10_10_10;
   localparam logic [8:0] LDX  = 9'b001_01_10_10;
   localparam logic [8:0] LDY  = 9'b001_10_01_10;
   localparam logic [8:0] WRZ  = 9'b001_10_10_01;
   localparam logic [8:0] CLR  = 9'b001_00_00_00;

   controlador_t_regs #(.EXEC_CYCLES(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .instr(instr), .ack(ack), .done(done),
      .busy(busy), .tx(tx), .ty(ty), .tz(tz), .ula_op(ula_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input string tag, input logic [8:0] exp);
      @(negedge clk);
      check(tag, {23'd0, ack, done, busy, tx, ty, tz}, {23'd0, exp});
   endtask

   // at most one T at load and never the 11 code, sampled every cycle out of reset
   always @(negedge clk)
      if (!rst)
         check("t_legal",
               {30'd0, (tx == 2'b11) || (ty == 2'b11) || (tz == 2'b11),
                       ((tx == 2'b01) + (ty == 2'b01) + (tz == 2'b01)) > 2'd1}, 32'd0);

   initial begin
      // reset and INIT
      repeat (3) step("reset_hold", ZERO);
      rst = 1'b0;
      step("init_cycle", ZERO);
      step("idle", IDL);
      // LOADX, instr changed after ack
      req = 1'b1; instr = 3'b001;
      step("ldx_ack", ACK);
      req = 1'b0; instr = 3'b111;
      step("ldx_decode", BSY);
      step("ldx_tx_load", LDX);
      step("ldx_done", DON);
      step("ldx_idle", IDL);
      // SUB with 2 settle cycles
      req = 1'b1; instr = 3'b100;
      step("sub_ack", ACK);
      req = 1'b0;
      step("sub_decode", BSY);
      check("sub_ula_entry", {30'd0, ula_op}, 32'd1);
      step("sub_exec1", BSY);
      step("sub_exec2", BSY);
      check("sub_ula_exec", {30'd0, ula_op}, 32'd1);
      step("sub_wrz", WRZ);
      step("sub_done", DON);
      check("sub_ula_hold", {30'd0, ula_op}, 32'd1);
      step("sub_idle", IDL);
      // NOP with req held: LOADY waits for IDLE after done
      req = 1'b1; instr = 3'b111;
      step("nop_ack", ACK);
      instr = 3'b010;
      step("busy_no_ack", BSY);
      step("nop_done_no_ack", DON);
      step("ldy_ack", ACK);
      req = 1'b0;
      step("ldy_decode", BSY);
      step("ldy_ty_load", LDY);
      step("ldy_done", DON);
      step("ldy_idle", IDL);
      // ADD aborted by reset during EXEC
      req = 1'b1; instr = 3'b011;
      step("add_ack", ACK);
      req = 1'b0;
      step("add_decode", BSY);
      check("add_ula", {30'd0, ula_op}, 32'd0);
      step("add_exec1", BSY);
      rst = 1'b1;
      #1 check("rst_async", {23'd0, ack, done, busy, tx, ty, tz}, {23'd0, ZERO});
      check("rst_ula", {30'd0, ula_op}, 32'd0);
      step("rst_no_wrz", ZERO);
      step("rst_no_done", ZERO);
      rst = 1'b0;
      step("rec_init", ZERO);
      step("rec_idle", IDL);
      step("rec_stay_idle", IDL);
      // back-to-back CLRALL then NOP with req held high
      req = 1'b1; instr = 3'b000;
      step("clr_ack", ACK);
      instr = 3'b111;
      step("clr_decode", BSY);
      step("clr_all_rst", CLR);
      step("clr_done", DON);
      step("nop2_ack", ACK);
      req = 1'b0;
      step("nop2_decode", BSY);
      step("nop2_done", DON);
      step("nop2_idle", IDL);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/controlador_t_regs.md
Name: controlador_t_regs

Overview:
- FSM controller that sequences the three 6-bit operand/result registers Tx, Ty, Tz and the ULA in the CPU datapath.
- Accepts one 3-bit instruction per request/acknowledge handshake.
- Drives each register's 2-bit T control: 00 = reset, 01 = load, 10 = hold.
- Selects the ULA operation and waits a configurable settle time before loading Tz.

Parameters:
EXEC_CYCLES, 2, ULA settle cycles between operand-stable and Tz load (legal range 1..15)
CNT_W, 4, width of settle counter; must hold EXEC_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  instruction request; instr is valid while req is high
instr  input  3  opcode: 000 CLRALL, 001 LOADX, 010 LOADY, 011 ADD, 100 SUB, 101 AND, 110 OR, 111 NOP
ack  output  1  one-cycle pulse: instruction accepted
done  output  1  one-cycle pulse: instruction completed
busy  output  1  high from accept through the done cycle
tx  output  2  T control for register Tx
ty  output  2  T control for register Ty
tz  output  2  T control for register Tz
ula_op  output  2  00 add, 01 sub, 10 and, 11 or

Behaviour:
- All outputs are registered from state, except ack, which is registered alongside the accept.
- Reset (async assert): tx=ty=tz=00, ula_op=00, ack=done=busy=0, state=INIT.
- Reset deassert: INIT lasts one clock with tx=ty=tz=00, then IDLE.
- IDLE:
  - tx=ty=tz=10 (hold), busy=0.
  - If req=1, latch instr, pulse ack for 1 cycle, busy=1, go to DECODE.
- DECODE (1 cycle, all hold), then by latched opcode:
  - CLRALL -> CLEAR
  - LOADX -> LDX
  - LOADY -> LDY
  - ADD/SUB/AND/OR -> EXEC
  - NOP -> FIN
- CLEAR: tx=ty=tz=00 for exactly 1 cycle -> FIN.
- LDX: tx=01 for 1 cycle, others hold -> FIN.
- LDY: ty=01 for 1 cycle, others hold -> FIN.
- EXEC:
  - ula_op set from opcode (ADD 00, SUB 01, AND 10, OR 11) and held through WRZ.
  - Counter loads EXEC_CYCLES-1 on entry and decrements each cycle; all T=10.
  - At count 0 -> WRZ.
  - EXEC therefore lasts exactly EXEC_CYCLES cycles.
- WRZ: tz=01 for 1 cycle -> FIN.
- FIN: done=1 for 1 cycle, all T=10, busy=1 -> IDLE.
- busy falls on the cycle after FIN.
- ula_op keeps its last value outside EXEC/WRZ.
- Latency from the ack cycle to the done cycle:
  - CLRALL, LOADX, LOADY: 3 cycles.
  - NOP: 2 cycles.
  - ALU ops: EXEC_CYCLES+3 cycles.
- req while busy: ignored, no ack. The requester must keep req high until ack.
- req high in the FIN cycle: not accepted; accepted in the following IDLE cycle.
- instr changing after ack: no effect, since the latched copy is used.
- Illegal/unknown state: next state is INIT.
- Reset asserted mid-instruction: immediate abort, outputs return to reset values, no done pulse.
- Never more than one T output at 01 in a cycle. CLEAR is the only state driving 00 after INIT.
- The T code 11 is never driven.

Decomposition:
- Shared package: T codes (T_RST=2'b00, T_LOAD=2'b01, T_HOLD=2'b10), opcode constants, ULA op constants, state encoding.
- One natural sub-module: contador_exec, a down-counter with load/enable and a zero flag, sized by CNT_W.
- FSM and output decode live in the top module.

Test Plan:
1. Reset held 3 cycles then released -> tx=ty=tz=00 during reset and for 1 cycle after; then 10/10/10; busy=0.
2. req=1, instr=001 (LOADX) -> ack at cycle 1; tx=01 for exactly 1 cycle at cycle 3; done at cycle 4; ty/tz stay 10 throughout.
3. instr=100 (SUB), EXEC_CYCLES=2 -> ula_op=01 during EXEC; tz=01 exactly 2 cycles after EXEC entry; done 5 cycles after ack.
4. Second req asserted while busy -> no ack until the IDLE cycle after done; second instruction then executes normally.
5. Reset asserted during EXEC of an ADD -> T outputs go to 00 asynchronously; no tz=01 and no done pulse; recovery through INIT to IDLE.
6. Back-to-back CLRALL, then NOP, with req held high -> tx=ty=tz=00 for exactly one cycle; NOP done 2 cycles after its ack; no T output ever 01 or 11.
